gin_feed_ctrl: RTL and testbench

Sequencer that feeds the global input network from the GLB.
- Reads a block of words from GLB SRAM at a linear address range.
- Attaches a {row,col} destination tag to each word.
- Streams words onto the GIN bus with valid/ready handshake.
- One instance per GIN; started by the top controller once per processing pass.

---
 rtl/gin_feed_ctrl_if.sv | 28 ++
 rtl/gin_feed_ctrl.sv | 153 +++++++++++++++
 tb/tb_gin_feed_ctrl.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gin_feed_ctrl_if.sv
// GLB read port and GIN output bus of the GIN feed sequencer.
//   master : sequencer side (drives GLB read strobe/address and the GIN word)
//   slave  : environment side (GLB returns read data, GIN returns ready)
//   o_glb_rd_en/o_glb_addr : GLB read request
//   i_glb_rd_data          : GLB read data, valid 1 cycle after the request
//   o_gin_valid/o_gin_data/o_gin_tag/i_gin_ready : GIN valid/ready stream
interface gin_feed_ctrl_if #(
  parameter int unsigned DATA_BITWIDTH = 16,
  parameter int unsigned ADDR_BITWIDTH = 10
);
  logic                     o_glb_rd_en;
  logic [ADDR_BITWIDTH-1:0] o_glb_addr;
  logic [DATA_BITWIDTH-1:0] i_glb_rd_data;
  logic                     o_gin_valid;
  logic [DATA_BITWIDTH-1:0] o_gin_data;
  logic [5:0]               o_gin_tag;
  logic                     i_gin_ready;

  modport master (
    output o_glb_rd_en, o_glb_addr, o_gin_valid, o_gin_data, o_gin_tag,
    input  i_glb_rd_data, i_gin_ready
  );

  modport slave (
    input  o_glb_rd_en, o_glb_addr, o_gin_valid, o_gin_data, o_gin_tag,
    output i_glb_rd_data, i_gin_ready
  );
endinterface

// File: rtl/gin_feed_ctrl.sv
// GIN feed sequencer: reads rows*cols*len words from a linear GLB address
// range (wrapping), tags each word with {row,col} and streams it onto the GIN
// through a 3-entry buffer with valid/ready handshake.
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_start             : start pulse, honoured only in IDLE
//   i_base_addr         : first GLB address
//   i_num_rows/cols     : row tags / col tags per row (0..7)
//   i_len               : words per {row,col} tag
//   bus (master)        : GLB read port and GIN output stream
//   o_busy              : high in every state except IDLE
//   o_done              : one-cycle pulse after a pass completes
module gin_feed_ctrl #(
  parameter int unsigned DATA_BITWIDTH = 16,
  parameter int unsigned ADDR_BITWIDTH = 10,
  parameter int unsigned LEN_BITWIDTH  = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic [ADDR_BITWIDTH-1:0] i_base_addr,
  input  logic [2:0]               i_num_rows,
  input  logic [2:0]               i_num_cols,
  input  logic [LEN_BITWIDTH-1:0]  i_len,
  gin_feed_ctrl_if.master          bus,
  output logic                     o_busy,
  output logic                     o_done
);

  localparam logic [ADDR_BITWIDTH-1:0] ADDR_ONE = 1;
  localparam logic [LEN_BITWIDTH-1:0]  LEN_ONE  = 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                   state_q, state_d;
  logic [ADDR_BITWIDTH-1:0] addr_q;
  logic [2:0]               rows_q, cols_q, row_cnt, col_cnt;
  logic [LEN_BITWIDTH-1:0]  len_q, word_cnt;
  logic                     rd_inflight;
  logic [5:0]               rd_tag;
  logic                     done_q;

  logic [DATA_BITWIDTH-1:0] buf_data [0:2];
  logic [5:0]               buf_tag  [0:2];
  logic [1:0]               wr_ptr, rd_ptr, count;

  logic rd_en, push, pop, size_zero;
  logic last_word, last_col, last_row, last_read;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign size_zero = (i_num_rows == '0) || (i_num_cols == '0) || (i_len == '0);
  assign last_word = (word_cnt == len_q - LEN_ONE);
  assign last_col  = (col_cnt == cols_q - 3'd1);
  assign last_row  = (row_cnt == rows_q - 3'd1);
  assign push      = rd_inflight;
  assign pop       = (count != '0) && bus.i_gin_ready;

  // Issue depends only on registered occupancy and in-flight state, so GIN
  // ready never reaches the GLB strobe combinationally. The sum never
  // exceeds 3, so 2 bits suffice.
  always_comb begin
    state_d   = state_q;
    rd_en     = 1'b0;
    last_read = 1'b0;
    if (state_q == RUN && !i_rst)
      rd_en = ((count + {1'b0, rd_inflight}) != 2'd3);
    last_read = rd_en && last_word && last_col && last_row;
    case (state_q)
      IDLE:    if (i_start) state_d = size_zero ? DONE : RUN;
      RUN:     if (last_read) state_d = DRAIN;
      DRAIN:   if (count == '0 && !rd_inflight) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rows_q      <= '0;
      cols_q      <= '0;
      len_q       <= '0;
      row_cnt     <= '0;
      col_cnt     <= '0;
      word_cnt    <= '0;
      rd_inflight <= 1'b0;
      rd_tag      <= '0;
      done_q      <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      for (int unsigned i = 0; i < 3; i++) begin
        buf_data[i] <= '0;
        buf_tag[i]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      done_q      <= (state_q == DONE);
      rd_inflight <= rd_en;

      if (state_q == IDLE && i_start) begin
        addr_q   <= i_base_addr;
        rows_q   <= i_num_rows;
        cols_q   <= i_num_cols;
        len_q    <= i_len;
        row_cnt  <= '0;
        col_cnt  <= '0;
        word_cnt <= '0;
      end

      if (rd_en) begin
        addr_q <= addr_q + ADDR_ONE;
        rd_tag <= {row_cnt, col_cnt};
        if (last_word) begin
          word_cnt <= '0;
          if (last_col) begin
            col_cnt <= '0;
            row_cnt <= row_cnt + 3'd1;
          end else begin
            col_cnt <= col_cnt + 3'd1;
          end
        end else begin
          word_cnt <= word_cnt + LEN_ONE;
        end
      end

      if (push) begin
        buf_data[wr_ptr] <= bus.i_glb_rd_data;
        buf_tag[wr_ptr]  <= rd_tag;
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);

      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign bus.o_glb_rd_en = rd_en;
  assign bus.o_glb_addr  = i_rst ? '0 : addr_q;
  assign bus.o_gin_valid = !i_rst && (count != '0);
  assign bus.o_gin_data  = i_rst ? '0 : buf_data[rd_ptr];
  assign bus.o_gin_tag   = i_rst ? '0 : buf_tag[rd_ptr];
  assign o_busy          = !i_rst && (state_q != IDLE);
  assign o_done          = !i_rst && done_q;

endmodule

// File: tb/tb_gin_feed_ctrl.sv
module tb_gin_feed_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [9:0] base_addr = '0;
  logic [2:0] num_rows = '0, num_cols = '0;
  logic [7:0] len = '0;
  logic       busy, done;

  gin_feed_ctrl_if #(.DATA_BITWIDTH(16), .ADDR_BITWIDTH(10)) bus ();

  gin_feed_ctrl #(.DATA_BITWIDTH(16), .ADDR_BITWIDTH(10), .LEN_BITWIDTH(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_base_addr(base_addr),
    .i_num_rows(num_rows), .i_num_cols(num_cols), .i_len(len),
    .bus(bus), .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t_start  = 0;

  // scoreboard queues: expected read addresses and expected {tag,data} words
  logic [9:0]  addr_q [$];
  logic [21:0] exp_q  [$];

  // per-pass observations from the monitor
  int first_rd = -1, first_valid = -1, done_cnt = 0, done_cyc = -1;
  int xfer_cnt = 0, rd_cnt = 0, last_xfer = -1;
  int ready_mode = 0;

  // bench-side occupancy/in-flight model built from observed handshakes
  int   occ = 0, infl = 0, max_occ = 0;
  logic prev_stall = 1'b0;
  logic [15:0] prev_data = '0;
  logic [5:0]  prev_tag = '0;
  logic        glb_pend = 1'b0;
  logic [9:0]  glb_pend_addr = '0;

  function automatic logic [15:0] glb_word(input logic [9:0] a);
    return {a[3:0], 2'b10, a} ^ 16'h5A3C;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  initial begin : ready_drv
    int unsigned rc = 0;
    bus.i_gin_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.i_gin_ready = (ready_mode == 0) ? 1'b1 : (rc % 3 == 0);
      rc++;
    end
  end

  initial begin : glb_drv
    bus.i_glb_rd_data = '0;
    forever begin
      @(posedge clk); #1;
      bus.i_glb_rd_data = glb_pend ? glb_word(glb_pend_addr) : 16'h0000;
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      glb_pend      = bus.o_glb_rd_en;
      glb_pend_addr = bus.o_glb_addr;
      if (rst) begin
        occ = 0; infl = 0; prev_stall = 1'b0;
      end else begin
        if (busy && addr_q.size() > 0)
          check_eq("rd_issue", bus.o_glb_rd_en, (occ + infl) < 3);
        if (bus.o_glb_rd_en) begin
          rd_cnt++;
          if (first_rd < 0) first_rd = cyc;
          check_eq("rd_expected", addr_q.size() != 0, 1);
          if (addr_q.size() != 0) check_eq("glb_addr", bus.o_glb_addr, addr_q.pop_front());
        end
        check_eq("valid_occ", bus.o_gin_valid, occ != 0);
        if (prev_stall) begin
          check_eq("stall_data", bus.o_gin_data, prev_data);
          check_eq("stall_tag", bus.o_gin_tag, prev_tag);
        end
        if (bus.o_gin_valid && first_valid < 0) first_valid = cyc;
        if (bus.o_gin_valid && bus.i_gin_ready) begin
          xfer_cnt++;
          last_xfer = cyc;
          check_eq("word_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            logic [21:0] e;
            e = exp_q.pop_front();
            check_eq("gin_data", bus.o_gin_data, e[15:0]);
            check_eq("gin_tag", bus.o_gin_tag, e[21:16]);
          end
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
          check_eq("busy_at_done", busy, 0);
        end
        prev_stall = bus.o_gin_valid && !bus.i_gin_ready;
        prev_data  = bus.o_gin_data;
        prev_tag   = bus.o_gin_tag;
        occ  = occ + infl - ((bus.o_gin_valid && bus.i_gin_ready) ? 1 : 0);
        infl = bus.o_glb_rd_en ? 1 : 0;
        if (occ > max_occ) max_occ = occ;
      end
    end
  end

  task automatic start_pass(input logic [9:0] b, input logic [2:0] r, input logic [2:0] c,
                            input logic [7:0] l);
    int unsigned idx = 0;
    first_rd = -1; first_valid = -1; done_cnt = 0; done_cyc = -1;
    xfer_cnt = 0; rd_cnt = 0; last_xfer = -1; max_occ = 0;
    if (r != 0 && c != 0 && l != 0)
      for (int unsigned ri = 0; ri < r; ri++)
        for (int unsigned ci = 0; ci < c; ci++)
          for (int unsigned wi = 0; wi < l; wi++) begin
            logic [9:0] a;
            a = b + 10'(idx);
            addr_q.push_back(a);
            exp_q.push_back({3'(ri), 3'(ci), glb_word(a)});
            idx++;
          end
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; num_rows = r; num_cols = c; len = l;
    t_start = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic finish_pass(input string name, input int nwords);
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (done_cnt > 0) break;
    end
    check_eq({name, "_done_seen"}, done_cnt > 0, 1);
    repeat (4) @(posedge clk);
    #1;
    check_eq({name, "_done_once"}, done_cnt, 1);
    check_eq({name, "_words"}, xfer_cnt, nwords);
    check_eq({name, "_reads"}, rd_cnt, nwords);
    check_eq({name, "_left"}, exp_q.size(), 0);
    check_eq({name, "_idle"}, busy, 0);
    check_eq({name, "_max_occ"}, max_occ <= 3, 1);
    if (nwords > 0) check_eq({name, "_done_late"}, done_cyc > last_xfer, 1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_rd_en", bus.o_glb_rd_en, 0);
    check_eq("rst_valid", bus.o_gin_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_addr", bus.o_glb_addr, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // basic pass with latency checks
    ready_mode = 0;
    start_pass(10'h010, 3'd2, 3'd2, 8'd2);
    finish_pass("basic", 8);
    check_eq("basic_first_rd", first_rd - t_start, 1);
    check_eq("basic_first_valid", first_valid - t_start, 3);

    // backpressure
    ready_mode = 1;
    start_pass(10'h010, 3'd2, 3'd2, 8'd2);
    finish_pass("bp", 8);
    ready_mode = 0;

    // zero size
    start_pass(10'h123, 3'd3, 3'd0, 8'd5);
    finish_pass("zero", 0);
    check_eq("zero_done_cyc", done_cyc - t_start, 2);
    check_eq("zero_no_valid", first_valid, -1);

    // address wrap
    start_pass(10'h3FE, 3'd1, 3'd1, 8'd4);
    finish_pass("wrap", 4);

    // start while busy is ignored
    start_pass(10'h100, 3'd2, 3'd3, 8'd3);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; base_addr = 10'h200; num_rows = 3'd1; num_cols = 3'd1; len = 8'd1;
    @(posedge clk); #1;
    start = 1'b0;
    finish_pass("busy_start", 18);

    // reset mid-run, then a clean pass
    start_pass(10'h040, 3'd2, 3'd2, 8'd4);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (xfer_cnt >= 3) break;
    end
    check_eq("rst_mid_reached", xfer_cnt >= 3, 1);
    rst = 1'b1;
    addr_q.delete();
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_rd_en", bus.o_glb_rd_en, 0);
    check_eq("mid_rst_addr", bus.o_glb_addr, 0);
    check_eq("mid_rst_valid", bus.o_gin_valid, 0);
    check_eq("mid_rst_data", bus.o_gin_data, 0);
    check_eq("mid_rst_tag", bus.o_gin_tag, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_done", done, 0);
    repeat (6) @(posedge clk);
    #1;
    check_eq("mid_rst_no_done", done_cnt, 0);
    start_pass(10'h040, 3'd2, 3'd2, 8'd4);
    finish_pass("after_rst", 16);
    check_eq("after_rst_first_valid", first_valid - t_start, 3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
